// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - registered signed add/sub built from a ripple chain of full-adder cells
// Result and signed-overflow flag update one clock after the operands are presented.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module ripple_adder #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] s;
  logic             ovf;

  // Subtraction is x + ~y + 1: invert y and inject sel as the carry-in.
  assign y_eff = y ^ {WIDTH{sel}};

  // Each cell keeps its own carry so the chain is a set of distinct nets, not one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic cin;
    logic cout;

    if (i == 0) begin : g_first
      assign cin = sel;
    end else begin : g_rest
      assign cin = g_cell[i-1].cout;
    end

    full_adder u_fa (
      .a    (x[i]),
      .b    (y_eff[i]),
      .cin  (cin),
      .s    (s[i]),
      .cout (cout)
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = g_cell[WIDTH-1].cout ^ g_cell[WIDTH-1].cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      sum      <= s;
      overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_ripple_adder.sv
// tb/tb_ripple_adder.sv - self-checking bench for ripple_adder against an integer arithmetic model

module tb_ripple_adder;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sel;
  logic [WIDTH-1:0] sum;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  ripple_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .sel      (sel),
    .sum      (sum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: true signed result, overflow if it falls outside the WIDTH-bit signed range.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic op, output logic [WIDTH-1:0] r,
                                output logic v);
    int av, bv, res;
    av  = (int'(a) >= (1 << (WIDTH-1))) ? int'(a) - (1 << WIDTH) : int'(a);
    bv  = (int'(b) >= (1 << (WIDTH-1))) ? int'(b) - (1 << WIDTH) : int'(b);
    res = op ? av - bv : av + bv;
    v   = (res > (1 << (WIDTH-1)) - 1) || (res < -(1 << (WIDTH-1)));
    r   = WIDTH'(res);
  endfunction

  task automatic step_check(input string tag);
    logic [WIDTH-1:0] er;
    logic             ev;
    model(x, y, sel, er, ev);
    @(posedge clk);
    #1;
    check({tag, "_sum"}, 32'(sum), 32'(er));
    check({tag, "_ovf"}, 32'(overflow), 32'(ev));
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic [WIDTH-1:0] r;
    logic             v;
  } vec_t;

  vec_t vecs[6] = '{
    '{6'b000001, 6'b111111, 1'b1, 6'b000010, 1'b0},
    '{6'b000011, 6'b000010, 1'b0, 6'b000101, 1'b0},
    '{6'b011111, 6'b000001, 1'b0, 6'b100000, 1'b1},
    '{6'b000000, 6'b100000, 1'b1, 6'b100000, 1'b1},
    '{6'b100000, 6'b000001, 1'b1, 6'b011111, 1'b1},
    '{6'b100000, 6'b100000, 1'b0, 6'b000000, 1'b1}
  };

  initial begin
    logic [12:0] combo;
    int          order[$];
    rst = 1'b1;
    x   = 6'b010101;
    y   = 6'b000011;
    sel = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_ovf", 32'(overflow), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_sum", 32'(sum), 32'b011000);
    check("post_reset_ovf", 32'(overflow), 32'd0);

    // Directed cases use hand-derived expectations, independent of the model.
    foreach (vecs[k]) begin
      x   = vecs[k].a;
      y   = vecs[k].b;
      sel = vecs[k].op;
      @(posedge clk);
      #1;
      check($sformatf("dir%0d_sum", k), 32'(sum), 32'(vecs[k].r));
      check($sformatf("dir%0d_ovf", k), 32'(overflow), 32'(vecs[k].v));
    end

    // Every operand/op combination, shuffled, presented back-to-back.
    for (int i = 0; i < (1 << 13); i++) order.push_back(i);
    order.shuffle();

    for (int i = 0; i < (1 << 13); i++) begin
      if (i == 4000) begin
        rst = 1'b1;
        x   = WIDTH'($urandom);
        y   = WIDTH'($urandom);
        sel = 1'($urandom);
        @(posedge clk);
        #1;
        check("mid_reset_sum", 32'(sum), 32'd0);
        check("mid_reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
      end
      combo = 13'(order[i]);
      x     = combo[5:0];
      y     = combo[11:6];
      sel   = combo[12];
      step_check("stream");
    end

    // Random stream with a random extra reset sprinkled in.
    for (int i = 0; i < 500; i++) begin
      x   = WIDTH'($urandom);
      y   = WIDTH'($urandom);
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rand_reset_sum", 32'(sum), 32'd0);
        check("rand_reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
      end else begin
        step_check("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
